// File: rtl/hall_sensor_conditioner_pkg.sv
// hall_pkg: sector codes and hall-code/sector helper functions for the hall conditioner
package hall_pkg;
  localparam logic [2:0] SECT_INVALID = 3'd0;
  localparam logic [2:0] SECT_1 = 3'd1;
  localparam logic [2:0] SECT_2 = 3'd2;
  localparam logic [2:0] SECT_3 = 3'd3;
  localparam logic [2:0] SECT_4 = 3'd4;
  localparam logic [2:0] SECT_5 = 3'd5;
  localparam logic [2:0] SECT_6 = 3'd6;
  localparam int NUM_SECT = 6;

  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    case (code)
      3'b001:  return SECT_1;
      3'b101:  return SECT_2;
      3'b100:  return SECT_3;
      3'b110:  return SECT_4;
      3'b010:  return SECT_5;
      3'b011:  return SECT_6;
      default: return SECT_INVALID;
    endcase
  endfunction

  function automatic logic [2:0] sect_next(input logic [2:0] s);
    return (s >= 3'(NUM_SECT)) ? SECT_1 : s + 3'd1;
  endfunction

  function automatic logic [2:0] sect_prev(input logic [2:0] s);
    return (s == SECT_1) ? 3'(NUM_SECT) : s - 3'd1;
  endfunction
endpackage

// File: rtl/hall_sensor_conditioner_glitch_filter.sv
// hall_glitch_filter: 2-FF sync of the hall code plus stable-count filter producing the accepted code
module hall_glitch_filter #(
  parameter int FILT_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_raw,
  output logic [2:0] o_code,
  output logic       o_edge,
  output logic       o_take,
  output logic [2:0] o_next
);
  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  logic [2:0]    r_s1, r_s2, r_cand, r_code;
  logic [CW-1:0] r_cnt;
  logic          r_edge;
  logic          w_take;
  // candidate always tracks last synced code, so a change in the synced code restarts the count
  assign w_take = (r_s2 != r_code) && (r_s2 == r_cand) && (r_cnt == CW'(FILT_CYCLES - 1));
  assign o_code = r_code;
  assign o_edge = r_edge;
  assign o_take = w_take;
  assign o_next = r_cand;
  // synchroniser, stable counter and accepted-code register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_code <= '0;
      r_cnt  <= '0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_cand <= r_s2;
      r_edge <= w_take;
      r_code <= w_take ? r_cand : r_code;
      r_cnt  <= (r_s2 == r_code || r_s2 != r_cand || w_take) ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/hall_sensor_conditioner.sv
// hall_sensor_conditioner: filtered hall code, sector, direction, fault and (with HALL_PERIOD_MEAS_EN) edge period
module hall_sensor_conditioner
  import hall_pkg::*;
#(
  parameter int FILT_CYCLES = 8,
  parameter int PER_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_h1,
  input  logic             i_h2,
  input  logic             i_h3,
  input  logic             i_fault_clr,
  output logic [2:0]       o_hall_out,
  output logic [2:0]       o_sector,
  output logic             o_edge,
  output logic             o_dir,
  output logic [PER_W-1:0] o_period,
  output logic             o_period_vld,
  output logic             o_stall,
  output logic             o_fault
);
  logic       w_take, w_both, w_fwd, w_rev, w_fault_set;
  logic [2:0] w_next, w_new_sect;
  logic [2:0] r_sector;
  logic       r_dir, r_fault;

  hall_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) u_filt (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_raw  ({i_h3, i_h2, i_h1}),
    .o_code (o_hall_out),
    .o_edge (o_edge),
    .o_take (w_take),
    .o_next (w_next)
  );

  // jump classification against the sector currently held; an invalid previous sector skips the check
  always_comb begin
    w_new_sect  = hall_to_sector(w_next);
    w_both      = (r_sector != SECT_INVALID) && (w_new_sect != SECT_INVALID);
    w_fwd       = w_both && (w_new_sect == sect_next(r_sector));
    w_rev       = w_both && (w_new_sect == sect_prev(r_sector));
    w_fault_set = w_take && ((w_new_sect == SECT_INVALID) || (w_both && !w_fwd && !w_rev));
  end

  // sector, direction and sticky fault, updated in the same cycle the filter accepts a code
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sector <= SECT_INVALID;
      r_dir    <= 1'b1;
      r_fault  <= 1'b0;
    end else begin
      r_sector <= w_take ? w_new_sect : r_sector;
      r_dir    <= (w_take && (w_fwd || w_rev)) ? w_fwd : r_dir;
      r_fault  <= w_fault_set || (r_fault && !i_fault_clr);
    end
  end

  assign o_sector = r_sector;
  assign o_dir    = r_dir;
  assign o_fault  = r_fault;

`ifdef HALL_PERIOD_MEAS_EN
  logic [PER_W-1:0] r_cnt, r_period;
  logic             r_pvld, r_seen, w_sat;
  assign w_sat = &r_cnt;
  // saturating edge-to-edge counter; a measurement is genuine only if bounded by two edges without saturation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_pvld   <= 1'b0;
      r_seen   <= 1'b0;
    end else begin
      r_cnt    <= w_take ? '0 : (w_sat ? r_cnt : r_cnt + 1'b1);
      r_period <= w_take ? (w_sat ? r_cnt : r_cnt + 1'b1) : r_period;
      r_pvld   <= w_take ? (r_seen && !w_sat) : r_pvld;
      r_seen   <= r_seen || w_take;
    end
  end
  assign o_period     = r_period;
  assign o_period_vld = r_pvld && !w_sat;
  assign o_stall      = w_sat;
`else
  assign o_period     = '0;
  assign o_period_vld = 1'b0;
  assign o_stall      = 1'b0;
`endif
endmodule

// File: tb/tb_hall_sensor_conditioner.sv
// tb_hall_sensor_conditioner: directed checks of filter, sector, direction, fault, period and reset
module tb_hall_sensor_conditioner;
`ifdef HALL_PERIOD_MEAS_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif
  localparam int P = 1000;
  logic        clk = 1'b0, rst_n = 1'b0, h1 = 1'b0, h2 = 1'b0, h3 = 1'b0, fault_clr = 1'b0;
  logic [2:0]  hall_out, sector;
  logic        edge_o, dir, period_vld, stall, fault;
  logic [15:0] period;
  int          n_chk = 0, n_fail = 0, edge_cnt = 0, e0;
  logic [2:0]  fwd [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b010, 3'b011};

  hall_sensor_conditioner #(.FILT_CYCLES(8), .PER_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_h1(h1), .i_h2(h2), .i_h3(h3), .i_fault_clr(fault_clr),
    .o_hall_out(hall_out), .o_sector(sector), .o_edge(edge_o), .o_dir(dir), .o_period(period),
    .o_period_vld(period_vld), .o_stall(stall), .o_fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (edge_o) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input int n);
    {h3, h2, h1} = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_hall"}, 32'(hall_out), 0);
    chk({pfx, "_sect"}, 32'(sector), 0);
    chk({pfx, "_edge"}, 32'(edge_o), 0);
    chk({pfx, "_dir"}, 32'(dir), 1);
    chk({pfx, "_period"}, 32'(period), 0);
    chk({pfx, "_pvld"}, 32'(period_vld), 0);
    chk({pfx, "_stall"}, 32'(stall), 0);
    chk({pfx, "_fault"}, 32'(fault), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(fwd[i % 6], P);
      chk("fwd_sect", 32'(sector), 32'(i % 6 + 1));
      chk("fwd_dir", 32'(dir), 1);
      chk("fwd_fault", 32'(fault), 0);
      if (i > 0) begin
        chk("fwd_period", 32'(period), MEAS ? P : 0);
        chk("fwd_pvld", 32'(period_vld), 32'(MEAS));
      end else chk("fwd_pvld_first", 32'(period_vld), 0);
    end
    for (int i = 0; i < 6; i++) begin
      drive(fwd[5 - i], P);
      chk("rev_sect", 32'(sector), 32'(6 - i));
      chk("rev_dir", 32'(dir), 0);
      chk("rev_fault", 32'(fault), 0);
      chk("rev_period", 32'(period), MEAS ? P : 0);
      chk("rev_pvld", 32'(period_vld), 32'(MEAS));
    end
    e0 = edge_cnt;
    drive(3'b011, 5);
    drive(3'b001, 20);
    chk("glitch_edges", 32'(edge_cnt), 32'(e0));
    chk("glitch_hall", 32'(hall_out), 32'h1);
    drive(3'b011, 10);
    chk("lat_edge_early", 32'(edge_o), 0);
    chk("lat_hall_early", 32'(hall_out), 32'h1);
    @(negedge clk);
    chk("lat_edge", 32'(edge_o), 1);
    chk("lat_hall", 32'(hall_out), 32'h3);
    chk("lat_sect", 32'(sector), 6);
    drive(3'b111, 30);
    chk("inv_sect", 32'(sector), 0);
    chk("inv_hall", 32'(hall_out), 32'h7);
    chk("inv_fault", 32'(fault), 1);
    {h3, h2, h1} = 3'b001;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    repeat (20) @(negedge clk);
    chk("clr_fault", 32'(fault), 0);
    chk("clr_sect", 32'(sector), 1);
    drive(3'b100, 20);
    chk("jump_fault", 32'(fault), 1);
    chk("jump_sect", 32'(sector), 3);
    chk("jump_dir", 32'(dir), 0);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("clr2_fault", 32'(fault), 0);
    drive(3'b011, 10);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("race_edge", 32'(edge_o), 1);
    chk("race_fault", 32'(fault), 1);
    chk("race_sect", 32'(sector), 6);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    drive(3'b001, 65600);
    chk("stall_set", 32'(stall), 32'(MEAS));
    chk("stall_pvld", 32'(period_vld), 0);
    chk("stall_dir", 32'(dir), 1);
    drive(3'b011, P);
    chk("unstall", 32'(stall), 0);
    chk("unstall_pvld", 32'(period_vld), 0);
    chk("unstall_sect", 32'(sector), 6);
    drive(3'b010, P);
    chk("post_pvld", 32'(period_vld), 32'(MEAS));
    chk("post_period", 32'(period), MEAS ? P : 0);
    chk("post_dir", 32'(dir), 0);
    chk("post_fault", 32'(fault), 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("after_hall", 32'(hall_out), 32'h2);
    chk("after_sect", 32'(sector), 5);
    chk("after_fault", 32'(fault), 0);
    chk("after_dir", 32'(dir), 1);
    chk("after_pvld", 32'(period_vld), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
